// File: rtl/mandel_pixel_scheduler.sv
// Mandelbrot frame scheduler: walks a frame in raster order, hands each
// pixel's c to the lowest free depth engine, and merges finished depths
// into a tagged valid/ready stream (completion order, round-robin).
// Optional build macro SCHED_PERF_EN adds a frame_cycles output holding the
// busy-cycle count of the last completed frame.

// One engine slot: FREE -> RUN1 -> RUN -> HOLD -> FREE.
// RUN1 is the cycle the start pulse is visible; done is still the stale level
// from the previous run there, so it is ignored.
module mandel_slot #(
  parameter int WORD_LENGTH = 32,
  parameter int X_BITS      = 10,
  parameter int Y_BITS      = 10
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   issue_i,
  input  logic [WORD_LENGTH-1:0] re_i,
  input  logic [WORD_LENGTH-1:0] im_i,
  input  logic [X_BITS-1:0]      x_i,
  input  logic [Y_BITS-1:0]      y_i,
  input  logic                   done_i,
  input  logic [9:0]             depth_i,
  input  logic                   accept_i,
  output logic                   free_o,
  output logic                   hold_o,
  output logic                   start_o,
  output logic [WORD_LENGTH-1:0] re_c_o,
  output logic [WORD_LENGTH-1:0] im_c_o,
  output logic [X_BITS-1:0]      x_o,
  output logic [Y_BITS-1:0]      y_o,
  output logic [9:0]             depth_o
);
  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_RUN1 = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]             state_q, state_d;
  logic                   start_q;
  logic [WORD_LENGTH-1:0] re_q, im_q;
  logic [X_BITS-1:0]      x_q;
  logic [Y_BITS-1:0]      y_q;
  logic [9:0]             depth_q;
  logic                   take;

  assign take = issue_i && (state_q == S_FREE);

  // slot lifecycle next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE:  if (issue_i)  state_d = S_RUN1;
      S_RUN1:                state_d = S_RUN;
      S_RUN:   if (done_i)   state_d = S_HOLD;
      S_HOLD:  if (accept_i) state_d = S_FREE;
      default:               state_d = S_FREE;
    endcase
  end

  // slot registers; c and tag only change on a new issue
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= S_FREE;
      start_q <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= take;
      if (take) begin
        re_q <= re_i;
        im_q <= im_i;
        x_q  <= x_i;
        y_q  <= y_i;
      end
      if ((state_q == S_RUN) && done_i) depth_q <= depth_i;
    end
  end

  assign free_o  = (state_q == S_FREE);
  assign hold_o  = (state_q == S_HOLD);
  assign start_o = start_q;
  assign re_c_o  = re_q;
  assign im_c_o  = im_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign depth_o = depth_q;
endmodule

module mandel_pixel_scheduler #(
  parameter int N_ENGINES   = 4,
  parameter int WORD_LENGTH = 32,
  parameter int FRAC        = 28,
  parameter int X_BITS      = 10,
  parameter int Y_BITS      = 10
) (
  input  logic                             sysclk,
  input  logic                             reset,
  input  logic                             frame_start,
  input  logic [X_BITS-1:0]                frame_width,
  input  logic [Y_BITS-1:0]                frame_height,
  input  logic [WORD_LENGTH-1:0]           re_origin,
  input  logic [WORD_LENGTH-1:0]           im_origin,
  input  logic [WORD_LENGTH-1:0]           step,
  output logic [N_ENGINES-1:0]             eng_start,
  output logic [N_ENGINES*WORD_LENGTH-1:0] eng_re_c,
  output logic [N_ENGINES*WORD_LENGTH-1:0] eng_im_c,
  input  logic [N_ENGINES-1:0]             eng_done,
  input  logic [N_ENGINES*10-1:0]          eng_depth,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic [X_BITS-1:0]                pix_x,
  output logic [Y_BITS-1:0]                pix_y,
  output logic [9:0]                       pix_depth,
  output logic                             busy,
  output logic                             frame_done
`ifdef SCHED_PERF_EN
  ,output logic [31:0]                     frame_cycles
`endif
);
  localparam int SLOT_W = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DISPATCH = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;
  localparam logic [X_BITS-1:0] X_ONE = 1;
  localparam logic [Y_BITS-1:0] Y_ONE = 1;

  // frame sequencer state
  logic [1:0]             state_q, state_d;
  logic [X_BITS-1:0]      w_q, w_d, x_q, x_d;
  logic [Y_BITS-1:0]      h_q, h_d, y_q, y_d;
  logic [WORD_LENGTH-1:0] re_org_q, re_org_d, step_q, step_d;
  logic [WORD_LENGTH-1:0] re_acc_q, re_acc_d, im_acc_q, im_acc_d;
  logic                   busy_q, busy_d, fdone_q, fdone_d;

  // per-slot views
  logic [N_ENGINES-1:0]                  free_v, hold_v, start_v, issue_v, accept_v;
  logic [N_ENGINES-1:0][WORD_LENGTH-1:0] re_v, im_v;
  logic [N_ENGINES-1:0][X_BITS-1:0]      tx_v;
  logic [N_ENGINES-1:0][Y_BITS-1:0]      ty_v;
  logic [N_ENGINES-1:0][9:0]             td_v;

  // output stage
  logic              out_valid_q, out_valid_d;
  logic [SLOT_W-1:0] out_slot_q, out_slot_d, ptr_q, ptr_d;
  logic [X_BITS-1:0] out_x_q, out_x_d;
  logic [Y_BITS-1:0] out_y_q, out_y_d;
  logic [9:0]        out_dep_q, out_dep_d;

  logic              issue_any, acc, found, drain_done;
  logic [SLOT_W-1:0] issue_idx, pick, base;
  logic [N_ENGINES-1:0] elig, cur_oh;

  function automatic logic [SLOT_W-1:0] nxt_slot(input logic [SLOT_W-1:0] s);
    if (int'(s) == N_ENGINES - 1) return '0;
    return s + SLOT_W'(1);
  endfunction

  assign acc        = out_valid_q && pix_ready;
  assign drain_done = (state_q == DRAIN) && (&free_v) && !out_valid_q;

  // lowest-index free slot gets the next pixel
  always_comb begin
    issue_any = 1'b0;
    issue_idx = '0;
    for (int k = N_ENGINES - 1; k >= 0; k--) begin
      if (free_v[k]) begin
        issue_any = 1'b1;
        issue_idx = SLOT_W'(k);
      end
    end
    issue_v = '0;
    if (state_q == DISPATCH && issue_any) issue_v[issue_idx] = 1'b1;
  end

  // frame sequencer and coordinate stepping
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    h_d      = h_q;
    re_org_d = re_org_q;
    step_d   = step_q;
    x_d      = x_q;
    y_d      = y_q;
    re_acc_d = re_acc_q;
    im_acc_d = im_acc_q;
    busy_d   = busy_q;
    fdone_d  = 1'b0;
    case (state_q)
      IDLE: if (frame_start) begin
        w_d      = frame_width;
        h_d      = frame_height;
        re_org_d = re_origin;
        step_d   = step;
        x_d      = '0;
        y_d      = '0;
        re_acc_d = re_origin;
        im_acc_d = im_origin;
        busy_d   = 1'b1;
        state_d  = (frame_width == '0 || frame_height == '0) ? DRAIN : DISPATCH;
      end
      DISPATCH: if (issue_any) begin
        if (x_q == w_q - X_ONE) begin
          x_d      = '0;
          y_d      = y_q + Y_ONE;
          re_acc_d = re_org_q;
          im_acc_d = im_acc_q - step_q;
          if (y_q == h_q - Y_ONE) state_d = DRAIN;
        end else begin
          x_d      = x_q + X_ONE;
          re_acc_d = re_acc_q + step_q;
        end
      end
      DRAIN: if (drain_done) begin
        fdone_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // frame sequencer registers
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      w_q      <= '0;
      h_q      <= '0;
      re_org_q <= '0;
      step_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      re_acc_q <= '0;
      im_acc_q <= '0;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      h_q      <= h_d;
      re_org_q <= re_org_d;
      step_q   <= step_d;
      x_q      <= x_d;
      y_q      <= y_d;
      re_acc_q <= re_acc_d;
      im_acc_q <= im_acc_d;
      busy_q   <= busy_d;
      fdone_q  <= fdone_d;
    end
  end

  // engine slots
  for (genvar g = 0; g < N_ENGINES; g++) begin : g_slot
    assign accept_v[g] = acc && (out_slot_q == SLOT_W'(g));
    mandel_slot #(
      .WORD_LENGTH(WORD_LENGTH), .X_BITS(X_BITS), .Y_BITS(Y_BITS)
    ) u_slot (
      .sysclk  (sysclk),
      .reset   (reset),
      .issue_i (issue_v[g]),
      .re_i    (re_acc_q),
      .im_i    (im_acc_q),
      .x_i     (x_q),
      .y_i     (y_q),
      .done_i  (eng_done[g]),
      .depth_i (eng_depth[g*10 +: 10]),
      .accept_i(accept_v[g]),
      .free_o  (free_v[g]),
      .hold_o  (hold_v[g]),
      .start_o (start_v[g]),
      .re_c_o  (re_v[g]),
      .im_c_o  (im_v[g]),
      .x_o     (tx_v[g]),
      .y_o     (ty_v[g]),
      .depth_o (td_v[g])
    );
  end

  // round-robin pick among held results, excluding the one already presented;
  // on acceptance the search starts just past the granted slot
  always_comb begin : arb
    int j;
    j      = 0;
    cur_oh = '0;
    cur_oh[out_slot_q] = out_valid_q;
    elig   = hold_v & ~cur_oh;
    base   = acc ? nxt_slot(out_slot_q) : ptr_q;
    found  = 1'b0;
    pick   = '0;
    for (int k = 0; k < N_ENGINES; k++) begin
      j = int'(base) + k;
      if (j >= N_ENGINES) j = j - N_ENGINES;
      if (!found && elig[j]) begin
        found = 1'b1;
        pick  = SLOT_W'(j);
      end
    end
  end

  // output beat register: only reloads when empty or being accepted
  always_comb begin
    out_valid_d = out_valid_q;
    out_slot_d  = out_slot_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_dep_d   = out_dep_q;
    ptr_d       = acc ? nxt_slot(out_slot_q) : ptr_q;
    if (!out_valid_q || acc) begin
      out_valid_d = found;
      if (found) begin
        out_slot_d = pick;
        out_x_d    = tx_v[pick];
        out_y_d    = ty_v[pick];
        out_dep_d  = td_v[pick];
      end
    end
  end

  // output stage registers
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_slot_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_dep_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_slot_q  <= out_slot_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_dep_q   <= out_dep_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef SCHED_PERF_EN
  logic [31:0] cyc_q, cyc_d, fc_q, fc_d;

  always_comb begin
    cyc_d = cyc_q;
    fc_d  = fc_q;
    if (state_q == IDLE && frame_start) cyc_d = '0;
    else if (busy_q)                    cyc_d = cyc_q + 32'd1;
    // the finishing cycle is itself a busy cycle, so latch the bumped count
    if (drain_done) fc_d = cyc_q + 32'd1;
  end

  // frame cycle counter and latched result
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      fc_q  <= '0;
    end else begin
      cyc_q <= cyc_d;
      fc_q  <= fc_d;
    end
  end

  assign frame_cycles = fc_q;
`endif

  assign eng_start  = start_v;
  assign eng_re_c   = re_v;
  assign eng_im_c   = im_v;
  assign pix_valid  = out_valid_q;
  assign pix_x      = out_x_q;
  assign pix_y      = out_y_q;
  assign pix_depth  = out_dep_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Directed bench for mandel_pixel_scheduler with behavioural depth engines.
module tb_mandel_pixel_scheduler;
  localparam int N = 4, W = 32, XB = 10, YB = 10;

  logic sysclk = 1'b0, reset = 1'b1;
  always #5 sysclk = ~sysclk;

  logic              frame_start = 1'b0;
  logic [XB-1:0]     frame_width = '0;
  logic [YB-1:0]     frame_height = '0;
  logic [W-1:0]      re_origin = '0, im_origin = '0, step = '0;
  logic [N-1:0]      eng_start, eng_done;
  logic [N*W-1:0]    eng_re_c, eng_im_c;
  logic [N*10-1:0]   eng_depth;
  logic              pix_valid, pix_ready = 1'b1;
  logic [XB-1:0]     pix_x;
  logic [YB-1:0]     pix_y;
  logic [9:0]        pix_depth;
  logic              busy, frame_done;
`ifdef SCHED_PERF_EN
  logic [31:0]       frame_cycles;
`endif

  mandel_pixel_scheduler #(.N_ENGINES(N)) dut (
    .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
    .frame_width(frame_width), .frame_height(frame_height),
    .re_origin(re_origin), .im_origin(im_origin), .step(step),
    .eng_start(eng_start), .eng_re_c(eng_re_c), .eng_im_c(eng_im_c),
    .eng_done(eng_done), .eng_depth(eng_depth),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_depth(pix_depth),
    .busy(busy), .frame_done(frame_done)
`ifdef SCHED_PERF_EN
    , .frame_cycles(frame_cycles)
`endif
  );

  // frame config the model expects (ignored frame_start pulses do not touch it)
  logic [W-1:0] cfg_re, cfg_im, cfg_step;

  function automatic logic [9:0] fdep(input logic [31:0] r, input logic [31:0] m);
    return r[31:22] ^ m[29:20];
  endfunction

  function automatic logic [9:0] exp_dep(input logic [XB-1:0] x, input logic [YB-1:0] y);
    logic [31:0] r, m;
    r = cfg_re + 32'(x) * cfg_step;
    m = cfg_im - 32'(y) * cfg_step;
    return fdep(r, m);
  endfunction

  // engine model: done drops on start, rises lat cycles later with the depth
  int lat[N];
  int cnt[N];
  always @(posedge sysclk or posedge reset) begin
    if (reset) begin
      eng_done  <= '0;
      eng_depth <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (eng_start[i]) begin
          eng_done[i] <= 1'b0;
          cnt[i]      <= lat[i];
        end else if (cnt[i] > 0) begin
          cnt[i] <= cnt[i] - 1;
          if (cnt[i] == 1) begin
            eng_done[i]           <= 1'b1;
            eng_depth[i*10 +: 10] <= fdep(eng_re_c[i*W +: W], eng_im_c[i*W +: W]);
          end
        end
      end
    end
  end

  // monitor
  int beats, fdones, starts, stab_err, dep_err;
  int seen[64];
  logic [19:0] order[16];
  logic [31:0] cap_re[16], cap_im[16];
  logic [31:0] held_re[N], held_im[N];

  always @(negedge sysclk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        held_re[i] <= '0;
        held_im[i] <= '0;
      end
    end else begin
      if (pix_valid && pix_ready) begin
        if (int'(pix_y) * 8 + int'(pix_x) < 64 && pix_x < 8)
          seen[int'(pix_y) * 8 + int'(pix_x)] <= seen[int'(pix_y) * 8 + int'(pix_x)] + 1;
        if (beats < 16) order[beats] <= {pix_x, pix_y};
        if (pix_depth !== exp_dep(pix_x, pix_y)) dep_err <= dep_err + 1;
        beats <= beats + 1;
      end
      if (frame_done) fdones <= fdones + 1;
      for (int i = 0; i < N; i++) begin
        if (eng_start[i]) begin
          if (starts < 16) begin
            cap_re[starts] <= eng_re_c[i*W +: W];
            cap_im[starts] <= eng_im_c[i*W +: W];
          end
          starts     <= starts + 1;
          held_re[i] <= eng_re_c[i*W +: W];
          held_im[i] <= eng_im_c[i*W +: W];
        end else if (eng_re_c[i*W +: W] !== held_re[i] || eng_im_c[i*W +: W] !== held_im[i]) begin
          stab_err <= stab_err + 1;
        end
      end
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    @(negedge sysclk);
    beats = 0; fdones = 0; starts = 0; stab_err = 0; dep_err = 0;
    for (int i = 0; i < 64; i++) seen[i] = 0;
    for (int i = 0; i < 16; i++) order[i] = '0;
  endtask

  task automatic start_frame(input int w, input int h, input logic [31:0] r,
                             input logic [31:0] m, input logic [31:0] s);
    cfg_re = r; cfg_im = m; cfg_step = s;
    @(posedge sysclk); #1;
    frame_width = XB'(w); frame_height = YB'(h);
    re_origin = r; im_origin = m; step = s;
    frame_start = 1'b1;
    @(posedge sysclk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (fdones == 0 && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    chk(tag, 64'(fdones == 0), 64'd0);
    repeat (3) @(negedge sysclk);
  endtask

  function automatic int uniq(input int w, input int h);
    int u;
    u = 0;
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        if (seen[yy * 8 + xx] == 1) u++;
    return u;
  endfunction

  localparam logic [31:0] RE0 = 32'hE000_0000;  // -2.0
  localparam logic [31:0] IM0 = 32'h1000_0000;  //  1.0
  localparam logic [31:0] ST0 = 32'h0800_0000;  //  0.5

  initial begin
    int n, snap_starts, hold_err;
    logic [29:0] sv;

    // reset state
    for (int i = 0; i < N; i++) lat[i] = 20;
    repeat (3) @(negedge sysclk);
    chk("rst_outs", 64'({busy, pix_valid, frame_done, eng_start}), 64'd0);
    chk("rst_c", 64'((|eng_re_c) | (|eng_im_c)), 64'd0);
    reset = 1'b0;
    clr();

    // reset in the middle of dispatch
    start_frame(4, 2, RE0, IM0, ST0);
    repeat (3) @(negedge sysclk);
    chk("pre_rst_issue", 64'(starts > 0), 64'd1);
    @(posedge sysclk); #2;
    reset = 1'b1;
    @(negedge sysclk);
    chk("midrst_outs", 64'({busy, pix_valid, frame_done, eng_start}), 64'd0);
    chk("midrst_c", 64'((|eng_re_c) | (|eng_im_c)), 64'd0);
    @(posedge sysclk); #1;
    reset = 1'b0;
    clr();
    repeat (30) @(negedge sysclk);
    chk("midrst_quiet", 64'({beats[7:0], fdones[7:0], starts[7:0]}), 64'd0);

    // 4x2 frame, fast engine 0, slow others
    lat[0] = 3;
    clr();
    start_frame(4, 2, RE0, IM0, ST0);
    wait_done(600, "f42_timeout");
    chk("f42_beats", 64'(beats), 64'd8);
    chk("f42_uniq", 64'(uniq(4, 2)), 64'd8);
    chk("f42_fdone", 64'(fdones), 64'd1);
    chk("f42_depth", 64'(dep_err), 64'd0);
    chk("f42_re_3_0", 64'(cap_re[3]), 64'hF800_0000);
    chk("f42_re_0_1", 64'(cap_re[4]), 64'hE000_0000);
    chk("f42_im_row1", 64'(cap_im[4]), 64'h0800_0000);
    chk("f42_im_3_1", 64'(cap_im[7]), 64'h0800_0000);
    chk("f42_ooo_2nd", 64'(order[1]), 64'({10'd0, 10'd1}));
    chk("f42_stable_c", 64'(stab_err), 64'd0);
    chk("f42_busy", 64'(busy), 64'd0);

    // back-pressure: all four done, ready low for 50 cycles
    for (int i = 0; i < N; i++) lat[i] = 3;
    clr();
    pix_ready = 1'b0;
    start_frame(4, 1, RE0, IM0, ST0);
    repeat (15) @(negedge sysclk);
    chk("bp_valid", 64'(pix_valid), 64'd1);
    sv = {pix_x, pix_y, pix_depth};
    snap_starts = starts;
    hold_err = 0;
    repeat (50) begin
      @(negedge sysclk);
      if (!pix_valid || {pix_x, pix_y, pix_depth} !== sv) hold_err++;
    end
    chk("bp_stable", 64'(hold_err), 64'd0);
    chk("bp_no_start", 64'(starts - snap_starts), 64'd0);
    chk("bp_first_x", 64'(sv[29:20]), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    @(posedge sysclk); #1;
    pix_ready = 1'b1;
    wait_done(200, "bp_timeout");
    chk("bp_beats", 64'(beats), 64'd4);
    chk("bp_rr_order", 64'({order[0][19:10], order[1][19:10], order[2][19:10], order[3][19:10]}),
        64'({10'd0, 10'd1, 10'd2, 10'd3}));
    chk("bp_depth", 64'(dep_err), 64'd0);

    // zero-width frame
    clr();
    @(posedge sysclk); #1;
    frame_width = '0; frame_height = YB'(2); frame_start = 1'b1;
    @(posedge sysclk); #1;
    frame_start = 1'b0;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!frame_done && n < 20);
    chk("zw_latency", 64'(n), 64'd2);
    repeat (3) @(negedge sysclk);
    chk("zw_no_start", 64'(starts), 64'd0);
    chk("zw_fdone", 64'(fdones), 64'd1);
    chk("zw_busy", 64'(busy), 64'd0);

    // frame_start while busy is ignored
    clr();
    start_frame(2, 2, RE0, IM0, ST0);
    repeat (2) @(posedge sysclk);
    #1;
    frame_width = XB'(3); frame_height = YB'(3); re_origin = 32'h1234_5678;
    frame_start = 1'b1;
    @(posedge sysclk); #1;
    frame_start = 1'b0;
    wait_done(300, "ign_timeout");
    repeat (20) @(negedge sysclk);
    chk("ign_beats", 64'(beats), 64'd4);
    chk("ign_uniq", 64'(uniq(2, 2)), 64'd4);
    chk("ign_fdone", 64'(fdones), 64'd1);
    chk("ign_depth", 64'(dep_err), 64'd0);
    chk("ign_idle", 64'(busy), 64'd0);

`ifdef SCHED_PERF_EN
    // frame cycle counter on a 1x1 frame
    clr();
    start_frame(1, 1, RE0, IM0, ST0);
    n = 0;
    repeat (40) begin
      @(negedge sysclk);
      if (busy) n++;
    end
    chk("perf_cycles", 64'(frame_cycles), 64'(n));
    chk("perf_nonzero", 64'(n > 0), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mandel_pixel_scheduler.md
Name: mandel_pixel_scheduler

Overview:
- Sequences a full Mandelbrot frame across N_ENGINES parallel depth_calculator instances.
- Generates the complex coordinate c for each pixel in raster order and dispatches pixels to free engines.
- Holds each engine's c stable while it runs, then collects depths into a tagged valid/ready pixel stream for the frame-buffer writer.
- Output order is completion order, not raster order. Each beat carries its x,y tag.

Parameters:
- N_ENGINES, 4, number of attached depth engines (1..16).
- WORD_LENGTH, 32, fixed-point width of c coordinates.
- FRAC, 28, fractional bits of c. Informational only; the block does no scaling.
- X_BITS, 10, width of the pixel x counter.
- Y_BITS, 10, width of the pixel y counter.

Ports:
- sysclk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  pulse; begins a frame when idle.
- frame_width  in  X_BITS  pixels per line; sampled on accepted frame_start.
- frame_height  in  Y_BITS  lines per frame; sampled on accepted frame_start.
- re_origin  in  WORD_LENGTH  signed re(c) of pixel (0,0); sampled on accepted frame_start.
- im_origin  in  WORD_LENGTH  signed im(c) of pixel (0,0); sampled on accepted frame_start.
- step  in  WORD_LENGTH  signed per-pixel increment; sampled on accepted frame_start.
- eng_start  out  N_ENGINES  one-cycle start pulse per engine.
- eng_re_c  out  N_ENGINES*WORD_LENGTH  per-engine re(c), registered.
- eng_im_c  out  N_ENGINES*WORD_LENGTH  per-engine im(c), registered.
- eng_done  in  N_ENGINES  per-engine done level.
- eng_depth  in  N_ENGINES*10  per-engine final_depth.
- pix_valid  out  1  result beat valid.
- pix_ready  in  1  downstream accepts beat.
- pix_x  out  X_BITS  pixel column of the beat.
- pix_y  out  Y_BITS  pixel row of the beat.
- pix_depth  out  10  escape depth of the beat.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset values: all outputs are 0. All engine slots are FREE. The state machine is in IDLE. Coordinate accumulators and counters are 0.
- Top-level state machine:
  - IDLE: frame_start=1 samples the frame inputs, sets x=y=0, re_acc=re_origin, im_acc=im_origin, busy=1, and moves to DISPATCH.
  - Zero-size frame: if frame_width==0 or frame_height==0, go to DRAIN instead of DISPATCH; frame_done pulses next cycle.
  - DISPATCH: issues pixels until the last pixel is issued, then moves to DRAIN.
  - DRAIN: waits until all slots are FREE and no result is pending, then pulses frame_done, clears busy, and returns to IDLE.
  - frame_start outside IDLE is ignored.
- Per-engine slot state machine, FREE -> RUN -> HOLD -> FREE:
  - Dispatch: in DISPATCH, at most one pixel is issued per cycle, to the lowest-index FREE slot.
  - On issue, in the same edge: eng_re_c[i]<=re_acc, eng_im_c[i]<=im_acc, tag[i]<={x,y}, eng_start[i]=1 for exactly one cycle, and the slot enters RUN.
  - eng_re_c[i] and eng_im_c[i] stay constant until that slot's next issue, because the engine reads c continuously.
  - RUN: eng_done[i] is ignored in the first cycle after start, since stale done from the previous run is still high. From the 2nd cycle after start, eng_done[i]=1 captures eng_depth[i] into the slot and the slot enters HOLD.
  - HOLD: the result waits for the output arbiter. The slot returns to FREE in the cycle its beat is accepted (pix_valid and pix_ready both 1).
  - A freed slot may be reissued on the next cycle, not the same cycle.
- Coordinate stepping on each issue:
  - If x==frame_width-1: x=0, y=y+1, re_acc=re_origin, im_acc=im_acc-step.
  - Otherwise: x=x+1, re_acc=re_acc+step.
  - All arithmetic is two's-complement and wraps mod 2^WORD_LENGTH, with no saturation.
  - The last pixel is x=frame_width-1, y=frame_height-1.
- Output:
  - A round-robin arbiter selects among HOLD slots. The pointer advances past the granted slot on acceptance.
  - While pix_valid=1 and pix_ready=0, pix_x, pix_y and pix_depth stay stable and the selection does not change.
  - Latency from eng_done capture to pix_valid is 1 cycle minimum.
- Simultaneous events: capture, issue and output acceptance on different slots in the same cycle are all allowed.
- Reset mid-frame: all slots return to FREE, no further beats are emitted, and no frame_done is produced. Engines are reset by the same reset.

Optional Feature:
- Macro: SCHED_PERF_EN.
- Defined: adds output port frame_cycles (32 bits).
  - A counter clears on accepted frame_start and increments every cycle while busy.
  - Its value is latched to frame_cycles on the frame_done pulse and held until the next frame_done.
  - frame_cycles resets to 0.
- Undefined: the port and counter are absent and there is no other change.

Test Plan:
- Reset mid-frame: assert reset during DISPATCH with N_ENGINES=4 -> all outputs 0, eng_start=0, busy=0; after release, a new frame_start works normally.
- 4x2 frame, re_origin=-2.0, im_origin=1.0, step=0.5 (Q4.28), pix_ready=1:
  - 8 beats, each {x,y} exactly once, frame_done pulsed once.
  - Captured eng_re_c for pixel (3,0) is -0.5.
  - Captured eng_im_c for row 1 is 0.5.
- Model engines with done latency 3 on engine 0 and 20 on others -> beats emerge out of raster order with correct tags; eng_re_c/eng_im_c are unchanged throughout each run.
- Hold pix_ready=0 for 50 cycles with all engines finished -> pix_valid held with stable beat, no eng_start issued, no result lost; releasing ready drains the 4 beats round-robin.
- frame_width=0 -> frame_done pulses 2 cycles after frame_start with no eng_start; frame_start pulsed while busy -> ignored and the frame result is unaffected.
- With SCHED_PERF_EN defined, 1x1 frame with a fixed-latency engine -> frame_cycles equals the measured busy-high cycle count.
